alu_issue_unit: RTL and testbench
=================================

# alu_issue_unit

Sequential initiator for the 16-bit combinational ALU: accepts operations over a valid/ready request channel, drives the ALU operand/opcode inputs from registers, captures `result`/`zero` one cycle later, checks them against a built-in golden model, and returns them through a small response FIFO. It sits between the decode/control logic and the ALU datapath. It also serves as the ALU's self-check harness in system simulation.

## Interface
- `WIDTH`, 16, operand/result width; must match the ALU
- `FIFO_DEPTH`, 2, response FIFO entries (power of two, ≥2)
- `CNT_W`, 16, width of the status counters
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request this cycle
- `req_a`, `req_b`  in  WIDTH  operands
- `req_op`  in  2  00 add, 01 xor, 10 pass B, 11 sub (a−b)
- `alu_a`, `alu_b`  out  WIDTH  registered ALU operand drive
- `alu_op`  out  2  registered ALU opcode drive
- `alu_result`  in  WIDTH  ALU result (combinational from `alu_*`)
- `alu_zero`  in  1  ALU zero flag
- `rsp_valid`  out  1  FIFO head valid
- `rsp_ready`  in  1  consumer accepts head
- `rsp_result`  out  WIDTH  head result
- `rsp_zero`  out  1  head zero flag
- `rsp_err`  out  1  head entry mismatched golden model
- `err_sticky`  out  1  any mismatch since reset
- `issue_count`  out  CNT_W  completed operations, saturating
- `zero_count`  out  CNT_W  completed operations with `alu_zero`=1, saturating
- `busy`  out  1  FSM in EXEC

## Operation
- FSM states: IDLE, EXEC.
- IDLE: `req_ready` = (fifo_count < FIFO_DEPTH). On `req_valid && req_ready`: latch `req_a/req_b/req_op` into `alu_a/alu_b/alu_op`, go to EXEC. Otherwise stay. `alu_*` hold their last values.
- EXEC: `req_ready`=0, `busy`=1. At the end of the cycle, push {`alu_result`, `alu_zero`, err} into the FIFO and return to IDLE. The push can never be blocked: the slot was guaranteed at acceptance and pops only free space.
- Golden model computes from the latched regs: add/sub modulo 2^WIDTH, xor, pass B; golden zero = (golden result == 0). err = (`alu_result` != golden) or (`alu_zero` != golden zero). An err push sets `err_sticky`, which clears only on reset.
- Counters increment on every push. `zero_count` increments only when `alu_zero`=1. Both saturate at 2^CNT_W−1 with no wrap.
- FIFO pop on `rsp_valid && rsp_ready`. Push and pop in the same cycle are allowed at any occupancy, including full with pop: the count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- `rsp_*` data is the FIFO head. It stays stable while `rsp_valid && !rsp_ready`.

## Timing
- Reset (`rst_n`=0 at an edge) forces state IDLE, FIFO empty, `alu_a`=`alu_b`=0, `alu_op`=00, counters 0, `err_sticky`=0. Resulting outputs: `rsp_valid`=0, `busy`=0, `req_ready`=1, `rsp_result`=0, `rsp_zero`=0, `rsp_err`=0.
- Reset asserted during EXEC aborts the operation. No push occurs and no counter increments.
- Request accepted at edge N; EXEC during cycle N..N+1; push at edge N+1; `rsp_valid`=1 from edge N+1 onward if the FIFO was empty. Latency is 1 cycle from acceptance to response.
- Peak throughput is one operation per 2 cycles. `req_ready` is never high in two consecutive cycles while requests are back-to-back.
- `req_ready` depends only on state and the registered FIFO count. There is no combinational path from `rsp_ready` to `req_ready`.

## Structure
- Shared package `alu_pkg`:
  - opcode constants `ALU_ADD`=2'b00, `ALU_XOR`=2'b01, `ALU_PASSB`=2'b10, `ALU_SUB`=2'b11, also used by the ALU itself;
  - FSM state encoding.
- One sub-module, `alu_rsp_fifo`: synchronous FIFO of width WIDTH+2 and depth FIFO_DEPTH, with count output.
- Golden model, FSM and counters stay in the top level.

## Test plan
- Reset, then issue add 0x0001+0x0001 → one cycle after acceptance, `rsp_result`=0x0002, `rsp_zero`=0, `rsp_err`=0, `issue_count`=1.
- Sub 0x0008−0x0008, then xor 0xFFFF^0x0000 → responses 0x0000/zero=1 then 0xFFFF/zero=0, `zero_count`=1, results returned in order.
- `rsp_ready` held 0 while issuing 3 requests (FIFO_DEPTH=2) → third request sees `req_ready`=0 until one pop. Third result is pass B 0x0010 from a=0xABCD.
- FIFO full with a pop and push in the same cycle → count stays 2 and no entry is lost or duplicated.
- Fault injection: bench forces `alu_result` to 0x5554 for add 0x1234+0x4321 → `rsp_err`=1 and `err_sticky`=1 until `rst_n` is pulsed.
- Reset asserted in EXEC → no response appears, counters are 0, and `req_ready`=1 on the next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and issue-unit FSM state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_XOR   = 2'b01;
  localparam logic [1:0] ALU_PASSB = 2'b10;
  localparam logic [1:0] ALU_SUB   = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } issue_state_e;

endpackage : alu_pkg

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; head is shown combinationally.
// Latency: a push is visible at the head one edge later when the FIFO was empty.
// Backpressure: caller must not push when full unless popping in the same cycle.
module alu_rsp_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_vld,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = cnt_q;

  // Storage, pointers (power-of-two depth wraps naturally) and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_vld) begin
        mem_q[wr_ptr_q] <= push_dat;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_vld) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_vld, pop_vld})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule : alu_rsp_fifo

// File: rtl/alu_issue_unit.sv
// Issues ops to the combinational ALU, checks its answer against a golden model, queues responses.
// Latency: response pushed one edge after request acceptance; one op per two cycles peak.
// Backpressure: req_ready drops while executing or when the response FIFO has no free slot.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] issue_count,
  output logic [CNT_W-1:0] zero_count,
  output logic             busy
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FCW-1:0] DEPTH_C = FCW'(FIFO_DEPTH);

  issue_state_e     state_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [1:0]       alu_op_q;
  logic             err_sticky_q;
  logic [CNT_W-1:0] issue_cnt_q, zero_cnt_q;

  logic [FCW-1:0]   fifo_cnt;
  logic [WIDTH+1:0] fifo_head;
  logic [WIDTH-1:0] golden_res;
  logic             golden_zero;
  logic             chk_err;
  logic             push;
  logic             pop;
  logic             accept;

  assign req_ready = (state_q == ST_IDLE) && (fifo_cnt < DEPTH_C);
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q == ST_EXEC);
  assign push      = (state_q == ST_EXEC);
  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid && rsp_ready;

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign err_sticky = err_sticky_q;
  assign issue_count = issue_cnt_q;
  assign zero_count  = zero_cnt_q;

  // Reference result computed from the same latched operands the ALU sees.
  always_comb begin
    golden_res = '0;
    case (alu_op_q)
      ALU_ADD:   golden_res = alu_a_q + alu_b_q;
      ALU_XOR:   golden_res = alu_a_q ^ alu_b_q;
      ALU_PASSB: golden_res = alu_b_q;
      ALU_SUB:   golden_res = alu_a_q - alu_b_q;
      default:   golden_res = '0;
    endcase
  end

  assign golden_zero = (golden_res == '0);
  assign chk_err     = (alu_result != golden_res) || (alu_zero != golden_zero);

  // Two-state issue FSM with operand/opcode registers that drive the ALU.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= ALU_ADD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            alu_a_q  <= req_a;
            alu_b_q  <= req_b;
            alu_op_q <= req_op;
            state_q  <= ST_EXEC;
          end
        end
        ST_EXEC: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Saturating completion counters and the sticky mismatch flag, updated on each push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_cnt_q  <= '0;
      zero_cnt_q   <= '0;
      err_sticky_q <= 1'b0;
    end else if (push) begin
      if (issue_cnt_q != '1)             issue_cnt_q <= issue_cnt_q + 1'b1;
      if (alu_zero && zero_cnt_q != '1)  zero_cnt_q  <= zero_cnt_q + 1'b1;
      if (chk_err)                       err_sticky_q <= 1'b1;
    end
  end

  alu_rsp_fifo #(
    .W     (WIDTH + 2),
    .DEPTH (FIFO_DEPTH),
    .CW    (FCW)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push),
    .push_dat ({alu_result, alu_zero, chk_err}),
    .pop_vld  (pop),
    .head_dat (fifo_head),
    .count    (fifo_cnt)
  );

  assign rsp_result = fifo_head[WIDTH+1:2];
  assign rsp_zero   = fifo_head[1];
  assign rsp_err    = fifo_head[0];

endmodule : alu_issue_unit

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU and a fault-injection override.
// Latency: checks assume push one edge after acceptance.
// Backpressure: rsp_ready is driven explicitly to hold and release the response FIFO.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [15:0] req_a, req_b;
  logic [1:0]  req_op;
  logic [15:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [15:0] alu_result, alu_model;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_zero, rsp_err, err_sticky, busy;
  logic [15:0] issue_count, zero_count;
  logic        fault_en;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Behavioural ALU; fault_en overrides its result to inject a wrong answer.
  always_comb begin
    alu_model = 16'h0000;
    case (alu_op)
      2'b00: alu_model = alu_a + alu_b;
      2'b01: alu_model = alu_a ^ alu_b;
      2'b10: alu_model = alu_b;
      2'b11: alu_model = alu_a - alu_b;
      default: alu_model = 16'h0000;
    endcase
  end
  assign alu_result = fault_en ? 16'h5554 : alu_model;
  assign alu_zero   = (alu_result == 16'h0000);

  alu_issue_unit #(.WIDTH(16), .FIFO_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .err_sticky(err_sticky), .issue_count(issue_count), .zero_count(zero_count),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the EXEC cycle with req_valid low.
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int n;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("issue_timeout", 32'd1, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic pop_one();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
    rsp_ready = 1'b0; fault_en = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_zero", rsp_zero, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_err_sticky", err_sticky, 0);
    check("rst_issue_count", issue_count, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_op", alu_op, 0);

    // Add 1+1
    issue(2'b00, 16'h0001, 16'h0001);
    check("add_busy", busy, 1);
    check("add_ready_exec", req_ready, 0);
    check("add_alu_a", alu_a, 16'h0001);
    check("add_no_rsp_yet", rsp_valid, 0);
    @(negedge clk);
    check("add_rsp_valid", rsp_valid, 1);
    check("add_result", rsp_result, 16'h0002);
    check("add_zero", rsp_zero, 0);
    check("add_err", rsp_err, 0);
    check("add_issue_count", issue_count, 1);
    check("add_idle", busy, 0);
    pop_one();
    check("add_popped", rsp_valid, 0);

    // Sub to zero then xor, drained in order
    issue(2'b11, 16'h0008, 16'h0008);
    issue(2'b01, 16'hFFFF, 16'h0000);
    @(negedge clk);
    check("sx_head_result", rsp_result, 16'h0000);
    check("sx_head_zero", rsp_zero, 1);
    check("sx_zero_count", zero_count, 1);
    check("sx_issue_count", issue_count, 3);
    pop_one();
    check("sx_second_result", rsp_result, 16'hFFFF);
    check("sx_second_zero", rsp_zero, 0);
    pop_one();
    check("sx_drained", rsp_valid, 0);

    // Backpressure: FIFO full blocks third request until a pop
    issue(2'b00, 16'h0002, 16'h0003);
    issue(2'b01, 16'hF0F0, 16'h0F0F);
    @(negedge clk);
    req_op = 2'b10; req_a = 16'hABCD; req_b = 16'h0010; req_valid = 1'b1;
    check("full_ready0", req_ready, 0);
    check("full_head_stable", rsp_result, 16'h0005);
    @(negedge clk);
    check("full_ready1", req_ready, 0);
    check("full_head_stable2", rsp_result, 16'h0005);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("full_ready_after_pop", req_ready, 1);
    check("full_next_head", rsp_result, 16'hFFFF);
    @(negedge clk);
    req_valid = 1'b0;
    check("pb_busy", busy, 1);
    // Push of pass-B coincides with pop of 0xFFFF
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("pp_rsp_valid", rsp_valid, 1);
    check("pp_head_passb", rsp_result, 16'h0010);
    check("pp_req_ready", req_ready, 1);
    pop_one();
    check("pp_no_dup", rsp_valid, 0);
    check("pp_issue_count", issue_count, 6);

    // Fault injection
    fault_en = 1'b1;
    issue(2'b00, 16'h1234, 16'h4321);
    @(negedge clk);
    fault_en = 1'b0;
    check("flt_result", rsp_result, 16'h5554);
    check("flt_rsp_err", rsp_err, 1);
    check("flt_sticky", err_sticky, 1);
    pop_one();
    issue(2'b00, 16'h0001, 16'h0002);
    @(negedge clk);
    check("flt_clean_err", rsp_err, 0);
    check("flt_clean_result", rsp_result, 16'h0003);
    check("flt_sticky_holds", err_sticky, 1);
    pop_one();
    do_reset();
    check("flt_sticky_cleared", err_sticky, 0);
    check("flt_count_cleared", issue_count, 0);

    // Reset during EXEC aborts the operation
    issue(2'b00, 16'h0005, 16'h0005);
    check("abort_in_exec", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_issue_count", issue_count, 0);
    check("abort_zero_count", zero_count, 0);
    check("abort_req_ready", req_ready, 1);
    check("abort_busy", busy, 0);
    @(negedge clk);
    check("abort_still_empty", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_alu_issue_unit
